// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Package     : fetch_pkg
// Description : Shared constants and helpers for the instruction fetch queue.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

   localparam int INSTR_W = 32;
   localparam int PC_INC  = 4;

   // MIPS canonical NOP (sll $0,$0,0); used as the reset value of buffered words
   localparam logic [INSTR_W-1:0] c_instr_nop = '0;

   // Width of a counter that must hold values 0..depth inclusive
   function automatic int count_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : DEPTH-entry synchronous FIFO of {pc, instr}. A slot is
//               reserved (PC written) when a request is issued and filled
//               (instruction written) when its response returns; only filled
//               slots are visible at the head.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DEPTH  = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           flush,
   input  logic                           reserve,
   input  logic [ADDR_W-1:0]              reserve_pc,
   input  logic                           fill,
   input  logic [INSTR_W-1:0]             fill_instr,
   input  logic                           pop,
   output logic [count_width(DEPTH)-1:0]  occupancy,
   output logic                           head_valid,
   output logic [ADDR_W-1:0]              head_pc,
   output logic [INSTR_W-1:0]             head_instr
);

   localparam int c_cnt_w = count_width(DEPTH);
   localparam int c_ptr_w = $clog2(DEPTH);

   logic [ADDR_W-1:0]  r_pc_mem    [DEPTH];
   logic [INSTR_W-1:0] r_instr_mem [DEPTH];
   logic [c_ptr_w-1:0] r_rsv_ptr;
   logic [c_ptr_w-1:0] r_fill_ptr;
   logic [c_ptr_w-1:0] r_pop_ptr;
   logic [c_cnt_w-1:0] r_occ;
   logic               w_pop;

   // A pop only counts when a filled entry is actually present
   assign w_pop      = pop && (r_occ != '0);
   assign occupancy  = r_occ;
   assign head_valid = (r_occ != '0);
   assign head_pc    = r_pc_mem[r_pop_ptr];
   assign head_instr = r_instr_mem[r_pop_ptr];

   // Pointer and filled-count bookkeeping; flush empties the queue in one cycle
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         r_rsv_ptr  <= '0;
         r_fill_ptr <= '0;
         r_pop_ptr  <= '0;
         r_occ      <= '0;
      end else begin
         if (reserve) r_rsv_ptr  <= r_rsv_ptr  + c_ptr_w'(1);
         if (fill)    r_fill_ptr <= r_fill_ptr + c_ptr_w'(1);
         if (w_pop)   r_pop_ptr  <= r_pop_ptr  + c_ptr_w'(1);
         r_occ <= r_occ + c_cnt_w'(fill) - c_cnt_w'(w_pop);
      end
   end

   // Storage: PC captured at reservation, instruction captured at fill
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_pc_mem[i]    <= '0;
            r_instr_mem[i] <= c_instr_nop;
         end
      end else begin
         if (reserve) r_pc_mem[r_rsv_ptr]     <= reserve_pc;
         if (fill)    r_instr_mem[r_fill_ptr] <= fill_instr;
      end
   end

endmodule
`default_nettype wire

// File: rtl/instruction_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_queue
// Description : Fetch stage with credit-based pipelined requests to a
//               variable-latency instruction memory, an in-order return
//               buffer, and redirect handling that flushes the queue and
//               squashes responses still in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch_queue
   import fetch_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter int                DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                redirect,
   input  logic [ADDR_W-1:0]   redirect_pc,
   output logic                imem_req_valid,
   input  logic                imem_req_ready,
   output logic [ADDR_W-1:0]   imem_req_addr,
   input  logic                imem_resp_valid,
   input  logic [INSTR_W-1:0]  imem_resp_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [ADDR_W-1:0]   out_pc,
   output logic [INSTR_W-1:0]  out_instr
);

   localparam int                 c_cnt_w = count_width(DEPTH);
   localparam logic [c_cnt_w:0]   c_depth = (c_cnt_w + 1)'(DEPTH);

   logic [ADDR_W-1:0]  r_fetch_pc;
   logic [c_cnt_w-1:0] r_inflight;
   logic [c_cnt_w-1:0] r_drop_cnt;
   logic [c_cnt_w-1:0] w_occupancy;
   logic [c_cnt_w:0]   w_credit_sum;
   logic [c_cnt_w-1:0] w_pending;
   logic               w_issue_ok;
   logic               w_req_fire;
   logic               w_fill;
   logic               w_pop;

   // Slots in use = words buffered + words still owed by memory
   assign w_credit_sum = {1'b0, w_occupancy} + {1'b0, r_inflight};

   // Issue only with a free slot, nothing left to squash and no redirect now
   assign w_issue_ok     = !rst && (w_credit_sum < c_depth) &&
                           (r_drop_cnt == '0) && !redirect;
   assign imem_req_valid = w_issue_ok;
   assign imem_req_addr  = r_fetch_pc;
   assign w_req_fire     = w_issue_ok && imem_req_ready;

   // A response lands in the queue only when it is not owed to a squashed request
   assign w_fill = imem_resp_valid && (r_drop_cnt == '0) && !redirect;

   // A pop during redirect is consumed by ID but the queue is flushed anyway
   assign w_pop = out_valid && out_ready && !redirect;

   // Every response still expected from memory at the time of a redirect
   assign w_pending = r_drop_cnt + r_inflight;

   // Fetch PC, outstanding-request count and squash counter
   always_ff @(posedge clk) begin
      if (rst) begin
         r_fetch_pc <= RESET_PC;
         r_inflight <= '0;
         r_drop_cnt <= '0;
      end else if (redirect) begin
         r_fetch_pc <= redirect_pc;
         r_inflight <= '0;
         // A response arriving with the redirect is itself one of the squashed ones
         if (imem_resp_valid && (w_pending != '0))
            r_drop_cnt <= w_pending - c_cnt_w'(1);
         else
            r_drop_cnt <= w_pending;
      end else begin
         if (w_req_fire)
            r_fetch_pc <= r_fetch_pc + ADDR_W'(PC_INC);
         r_inflight <= r_inflight + c_cnt_w'(w_req_fire) - c_cnt_w'(w_fill);
         if (imem_resp_valid && (r_drop_cnt != '0))
            r_drop_cnt <= r_drop_cnt - c_cnt_w'(1);
      end
   end

   fetch_fifo #(
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .flush      (redirect),
      .reserve    (w_req_fire),
      .reserve_pc (r_fetch_pc),
      .fill       (w_fill),
      .fill_instr (imem_resp_data),
      .pop        (w_pop),
      .occupancy  (w_occupancy),
      .head_valid (out_valid),
      .head_pc    (out_pc),
      .head_instr (out_instr)
   );

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch_queue
// Description : Self-checking bench for instruction_fetch_queue with an
//               in-order variable-latency memory model and a PC/instr
//               scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch_queue;
   import fetch_pkg::*;

   localparam int          ADDR_W   = 32;
   localparam int          DEPTH    = 4;
   localparam logic [31:0] c_reset_pc = 32'h0;

   logic        clk;
   logic        rst;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_instr;

   instruction_fetch_queue #(
      .ADDR_W   (ADDR_W),
      .DEPTH    (DEPTH),
      .RESET_PC (c_reset_pc)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .redirect        (redirect),
      .redirect_pc     (redirect_pc),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_pc          (out_pc),
      .out_instr       (out_instr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } mem_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   typedef struct {
      logic        oready;
      logic        rv;
      logic [31:0] ra;
      logic        ov;
      logic [31:0] opc;
   } vec_t;

   mem_t        mem_q[$];
   exp_t        sb_q[$];
   vec_t        tbl[12];
   int          total;
   int          bad;
   int          cyc;
   int          mem_lat;
   int          pops;
   logic [31:0] model_pc;
   logic        s_req_valid;
   logic [31:0] s_req_addr;
   logic        s_out_valid;
   logic [31:0] s_out_pc;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // One clock cycle: drive memory response, sample mid-cycle, update models
   task automatic cycle();
      exp_t e;
      if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
         imem_resp_valid = 1'b1;
         imem_resp_data  = mem_word(mem_q[0].addr);
      end else begin
         imem_resp_valid = 1'b0;
         imem_resp_data  = '0;
      end
      #4;
      s_req_valid = imem_req_valid;
      s_req_addr  = imem_req_addr;
      s_out_valid = out_valid;
      s_out_pc    = out_pc;
      if (rst) begin
         chk("req_valid_in_rst", {31'b0, imem_req_valid}, 32'd0);
         mem_q.delete();
         sb_q.delete();
         model_pc = c_reset_pc;
      end else begin
         if (imem_resp_valid) void'(mem_q.pop_front());
         if (out_valid && out_ready) begin
            pops++;
            if (sb_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_output: got pc %h want none", out_pc);
            end else begin
               e = sb_q.pop_front();
               chk("out_pc", out_pc, e.pc);
               chk("out_instr", out_instr, e.instr);
            end
         end
         if (imem_req_valid && imem_req_ready)
            mem_q.push_back('{addr: imem_req_addr, due: cyc + mem_lat});
         if (redirect) begin
            sb_q.delete();
            model_pc = redirect_pc;
         end else if (imem_req_valid && imem_req_ready) begin
            chk("req_addr", imem_req_addr, model_pc);
            sb_q.push_back('{pc: model_pc, instr: mem_word(model_pc)});
            model_pc = model_pc + 32'd4;
         end
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cycle();
      cycle();
      chk("reset_out_valid", {31'b0, s_out_valid}, 32'd0);
      rst = 1'b0;
   endtask

   task automatic wait_out_valid(input int budget, input string name, input logic [31:0] exp_pc);
      bit found;
      found = 1'b0;
      for (int i = 0; i < budget; i++) begin
         cycle();
         if (s_out_valid) begin
            found = 1'b1;
            break;
         end
      end
      if (!found) begin
         total++;
         bad++;
         $display("FAIL %s_timeout: got no out_valid want out_valid within %0d cycles", name, budget);
      end else begin
         chk(name, s_out_pc, exp_pc);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      total = 0; bad = 0; cyc = 0; pops = 0;
      mem_lat = 1; model_pc = c_reset_pc;
      rst = 1'b1; redirect = 1'b0; redirect_pc = '0;
      imem_req_ready = 1'b1; out_ready = 1'b1;
      imem_resp_valid = 1'b0; imem_resp_data = '0;

      // Stall-then-drain vectors (1-cycle memory), starting right after reset
      tbl[0]  = '{1'b0, 1'b1, 32'h00, 1'b0, 32'h00};
      tbl[1]  = '{1'b0, 1'b1, 32'h04, 1'b0, 32'h00};
      tbl[2]  = '{1'b0, 1'b1, 32'h08, 1'b1, 32'h00};
      tbl[3]  = '{1'b0, 1'b1, 32'h0C, 1'b1, 32'h00};
      tbl[4]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h00};
      tbl[5]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h00};
      tbl[6]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h00};
      tbl[7]  = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h00};
      tbl[8]  = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h04};
      tbl[9]  = '{1'b1, 1'b1, 32'h14, 1'b1, 32'h08};
      tbl[10] = '{1'b1, 1'b1, 32'h18, 1'b1, 32'h0C};
      tbl[11] = '{1'b1, 1'b1, 32'h1C, 1'b1, 32'h10};

      @(negedge clk);

      // Test 1: streaming, one word per cycle after a 2-cycle fill
      do_reset();
      pops = 0;
      repeat (20) cycle();
      chk("t1_pops", pops, 32'd18);

      // Test 2: table-driven stall and drain
      out_ready = 1'b0;
      do_reset();
      for (int i = 0; i < 12; i++) begin
         out_ready = tbl[i].oready;
         cycle();
         chk($sformatf("t2_req_valid[%0d]", i), {31'b0, s_req_valid}, {31'b0, tbl[i].rv});
         if (tbl[i].rv) chk($sformatf("t2_req_addr[%0d]", i), s_req_addr, tbl[i].ra);
         chk($sformatf("t2_out_valid[%0d]", i), {31'b0, s_out_valid}, {31'b0, tbl[i].ov});
         if (tbl[i].ov) chk($sformatf("t2_out_pc[%0d]", i), s_out_pc, tbl[i].opc);
      end
      repeat (6) cycle();

      // Test 3: 3-cycle memory, redirect with 3 requests outstanding
      out_ready = 1'b1;
      mem_lat = 3;
      do_reset();
      repeat (3) cycle();
      redirect = 1'b1; redirect_pc = 32'h400;
      cycle();
      redirect = 1'b0;
      chk("t3_req_valid_redirect", {31'b0, s_req_valid}, 32'd0);
      cycle();
      chk("t3_req_valid_drain1", {31'b0, s_req_valid}, 32'd0);
      cycle();
      chk("t3_req_valid_drain2", {31'b0, s_req_valid}, 32'd0);
      cycle();
      chk("t3_req_valid_resume", {31'b0, s_req_valid}, 32'd1);
      chk("t3_req_addr_resume", s_req_addr, 32'h400);
      wait_out_valid(10, "t3_first_out_pc", 32'h400);
      repeat (5) cycle();

      // Test 4: redirect coinciding with a response and a pop
      mem_lat = 2;
      do_reset();
      repeat (4) cycle();
      redirect = 1'b1; redirect_pc = 32'h800;
      cycle();
      redirect = 1'b0;
      chk("t4_pop_in_redirect_valid", {31'b0, s_out_valid}, 32'd1);
      chk("t4_pop_in_redirect_pc", s_out_pc, 32'h4);
      cycle();
      chk("t4_out_valid_after", {31'b0, s_out_valid}, 32'd0);
      chk("t4_req_valid_drop", {31'b0, s_req_valid}, 32'd0);
      cycle();
      chk("t4_req_valid_resume", {31'b0, s_req_valid}, 32'd1);
      chk("t4_req_addr_resume", s_req_addr, 32'h800);
      repeat (6) cycle();

      // Test 5: PC wraps from the top of the address space
      mem_lat = 1;
      do_reset();
      redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      cycle();
      redirect = 1'b0;
      cycle();
      chk("t5_req_addr_top", s_req_addr, 32'hFFFF_FFFC);
      cycle();
      chk("t5_req_valid_wrap", {31'b0, s_req_valid}, 32'd1);
      chk("t5_req_addr_wrap", s_req_addr, 32'h0);
      cycle();
      chk("t5_out_pc_top", s_out_pc, 32'hFFFF_FFFC);
      cycle();
      chk("t5_out_pc_wrap", s_out_pc, 32'h0);

      // Test 6: reset with two buffered words and two requests in flight
      mem_lat = 3;
      out_ready = 1'b0;
      do_reset();
      repeat (5) cycle();
      cycle();
      chk("t6_pre_out_valid", {31'b0, s_out_valid}, 32'd1);
      chk("t6_pre_out_pc", s_out_pc, 32'h0);
      chk("t6_pre_req_valid", {31'b0, s_req_valid}, 32'd0);
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      out_ready = 1'b1;
      cycle();
      chk("t6_post_out_valid", {31'b0, s_out_valid}, 32'd0);
      chk("t6_post_req_valid", {31'b0, s_req_valid}, 32'd1);
      chk("t6_post_req_addr", s_req_addr, c_reset_pc);
      wait_out_valid(10, "t6_first_out_pc", c_reset_pc);
      repeat (6) cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
